// File: rtl/prbs_checker_5.sv
// Receive-side checker for a 5-bit Fibonacci LFSR stream: self-seeds, syncs, locks, counts errors.
// Latency: locked/err/err_cnt update one clock after the sampled valid bit.
// Backpressure: none; din is consumed on every din_vld cycle and idle cycles leave all state untouched.
// Optional bit counter (BER denominator) is built only when PRBS_CHK_BITCNT_EN is defined.
module prbs_checker_5 #(
   parameter int               WIDTH    = 5,
   parameter logic [WIDTH-1:0] TAPS     = 5'b10100,
   parameter int               LOCK_CNT = 16,
   parameter int               LOSS_ERR = 4,
   parameter int               ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_vld,
   output logic             locked,
   output logic             err,
`ifdef PRBS_CHK_BITCNT_EN
   output logic [31:0]      bit_cnt,
`endif
   output logic [ERR_W-1:0] err_cnt
);

   localparam int SC_W = $clog2(WIDTH + 1);
   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam int LC_W = $clog2(LOSS_ERR + 1);

   // Terminal values: a counter sitting at *_LAST is about to take its final increment.
   localparam logic [SC_W-1:0] SEED_LAST = SC_W'(WIDTH - 1);
   localparam logic [MC_W-1:0] RUN_LAST  = MC_W'(LOCK_CNT - 1);
   localparam logic [LC_W-1:0] LOSS_LAST = LC_W'(LOSS_ERR - 1);

   typedef enum logic [1:0] {S_SEED, S_SYNC, S_LOCKED} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [SC_W-1:0]  seed_cnt;
   logic [MC_W-1:0]  match_cnt;
   logic [MC_W-1:0]  good_run;
   logic [LC_W-1:0]  loss_cnt;

   logic             pred;
   logic             mismatch;
   logic [WIDTH-1:0] sr_din;
   logic [WIDTH-1:0] sr_pred;

   // Prediction from the pre-update register, plus both candidate next register values.
   always_comb begin
      pred     = ^(sr & TAPS);
      mismatch = din ^ pred;
      sr_din   = {sr[WIDTH-2:0], din};
      sr_pred  = {sr[WIDTH-2:0], pred};
   end

   // Seed / sync / locked sequencing with flywheel prediction and error accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_SEED;
         sr        <= '0;
         seed_cnt  <= '0;
         match_cnt <= '0;
         loss_cnt  <= '0;
         good_run  <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
`ifdef PRBS_CHK_BITCNT_EN
         bit_cnt   <= '0;
`endif
      end else begin
         err <= 1'b0;
         if (din_vld) begin
            case (state)
               S_SEED: begin
                  sr <= sr_din;
                  if (seed_cnt == SEED_LAST) begin
                     seed_cnt <= '0;
                     // An all-zero seed is the LFSR lockup state; keep collecting.
                     if (sr_din != '0) begin
                        state     <= S_SYNC;
                        match_cnt <= '0;
                     end
                  end else begin
                     seed_cnt <= seed_cnt + 1'b1;
                  end
               end
               S_SYNC: begin
                  sr <= sr_din;
                  if (mismatch || sr_din == '0) begin
                     state    <= S_SEED;
                     seed_cnt <= '0;
                  end else if (match_cnt == RUN_LAST) begin
                     state     <= S_LOCKED;
                     locked    <= 1'b1;
                     match_cnt <= '0;
                     good_run  <= '0;
                     loss_cnt  <= '0;
                  end else begin
                     match_cnt <= match_cnt + 1'b1;
                  end
               end
               S_LOCKED: begin
                  // Flywheel: the local sequence advances on its own prediction.
                  sr <= sr_pred;
`ifdef PRBS_CHK_BITCNT_EN
                  if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
`endif
                  if (mismatch) begin
                     err      <= 1'b1;
                     good_run <= '0;
                     if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                     if (loss_cnt == LOSS_LAST) begin
                        state    <= S_SEED;
                        locked   <= 1'b0;
                        seed_cnt <= '0;
                        loss_cnt <= '0;
                     end else begin
                        loss_cnt <= loss_cnt + 1'b1;
                     end
                  end else if (good_run == RUN_LAST) begin
                     good_run <= '0;
                     loss_cnt <= '0;
                  end else begin
                     good_run <= good_run + 1'b1;
                  end
               end
               default: begin
                  state    <= S_SEED;
                  seed_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs_checker_5.sv
// Bench for prbs_checker_5: m-sequence stream from a history-based generator,
// a bit-history reference model, directed lock/loss/reset scenarios and a random soak.
// Optional bit counter is compared when PRBS_CHK_BITCNT_EN is defined.
module tb_prbs_checker_5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic        din_vld = 1'b0;
   logic        locked;
   logic        err;
   logic [15:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
   logic [31:0] bit_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   prbs_checker_5 dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .din_vld (din_vld),
      .locked  (locked),
      .err     (err),
`ifdef PRBS_CHK_BITCNT_EN
      .bit_cnt (bit_cnt),
`endif
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   // Generator: b[n] = b[n-3] xor b[n-5], first five bits 0,0,0,0,1.
   bit g_hist[$];
   int g_n;

   task automatic gen_reset();
      g_hist.delete();
      g_n = 0;
   endtask

   task automatic gen_next(output bit b);
      if (g_n < 5) b = (g_n == 4);
      else         b = g_hist[$-2] ^ g_hist[$-4];
      g_hist.push_back(b);
      if (g_hist.size() > 8) void'(g_hist.pop_front());
      g_n++;
   endtask

   // Reference model: mode 0 = seeding, 1 = syncing, 2 = locked.
   bit     m_hist[$];
   int     m_mode, m_seed, m_match, m_good, m_loss;
   bit     m_err;
   int     m_errc;
   longint m_bits;

   task automatic model_reset();
      m_hist.delete();
      m_mode = 0; m_seed = 0; m_match = 0; m_good = 0; m_loss = 0;
      m_err = 0; m_errc = 0; m_bits = 0;
   endtask

   function automatic bit last5_zero();
      return (m_hist[$] | m_hist[$-1] | m_hist[$-2] | m_hist[$-3] | m_hist[$-4]) == 1'b0;
   endfunction

   task automatic model_bit(input bit b);
      bit p;
      if (m_mode == 0) begin
         m_hist.push_back(b);
         m_seed++;
         if (m_seed == 5) begin
            m_seed = 0;
            if (!last5_zero()) begin m_mode = 1; m_match = 0; end
         end
      end else if (m_mode == 1) begin
         p = m_hist[$-2] ^ m_hist[$-4];
         m_hist.push_back(b);
         if (b != p || last5_zero()) begin
            m_mode = 0; m_seed = 0;
         end else begin
            m_match++;
            if (m_match == 16) begin m_mode = 2; m_good = 0; m_loss = 0; end
         end
      end else begin
         p = m_hist[$-2] ^ m_hist[$-4];
         m_hist.push_back(p);
         if (m_bits < 64'hFFFF_FFFF) m_bits++;
         if (b != p) begin
            m_err = 1;
            if (m_errc < 16'hFFFF) m_errc++;
            m_loss++;
            m_good = 0;
            if (m_loss == 4) begin m_mode = 0; m_seed = 0; m_loss = 0; end
         end else begin
            m_good++;
            if (m_good == 16) begin m_good = 0; m_loss = 0; end
         end
      end
      if (m_hist.size() > 8) void'(m_hist.pop_front());
   endtask

   // One clock: drive inputs, let the edge pass, advance the model.
   task automatic cyc(input bit r, input bit v, input bit b);
      rst = r; din_vld = v; din = b;
      @(posedge clk);
      #1;
      m_err = 0;
      if (r)      model_reset();
      else if (v) model_bit(b);
   endtask

   function automatic logic [49:0] obs();
`ifdef PRBS_CHK_BITCNT_EN
      return {locked, err, err_cnt, bit_cnt};
`else
      return {locked, err, err_cnt, 32'd0};
`endif
   endfunction

   function automatic logic [49:0] expv();
`ifdef PRBS_CHK_BITCNT_EN
      return {m_mode == 2, m_err, m_errc[15:0], m_bits[31:0]};
`else
      return {m_mode == 2, m_err, m_errc[15:0], 32'd0};
`endif
   endfunction

   // Reset, then feed a clean stream until the checker should be locked.
   task automatic lock_up();
      bit b;
      gen_reset();
      cyc(1, 0, 0);
      for (int n = 1; n <= 21; n++) begin
         gen_next(b);
         cyc(0, 1, b);
      end
      vectors++;
      if (locked !== 1'b1) begin
         miscompares++;
         $display("FAIL lock_up: locked=%b want 1", locked);
      end
   endtask

   task automatic test_reset();
      cyc(1, 0, 0);
      cyc(1, 1, 1);
      vectors++;
      if (obs() !== 50'd0) begin
         miscompares++;
         $display("FAIL reset_state: got %h want 0", obs());
      end
   endtask

   task automatic test_clean_lock();
      bit b;
      gen_reset();
      cyc(1, 0, 0);
      for (int n = 1; n <= 1000; n++) begin
         gen_next(b);
         cyc(0, 1, b);
         vectors++;
         if ({locked, err, err_cnt} !== {n >= 21, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL clean_lock bit %0d: got %b/%b/%0d want %b/0/0", n, locked, err, err_cnt, n >= 21);
         end
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL clean_model bit %0d: got %h want %h", n, obs(), expv());
         end
      end
   endtask

   task automatic test_gapped();
      bit b, v;
      int n = 0;
      gen_reset();
      cyc(1, 0, 0);
      for (int c = 0; c < 100; c++) begin
         v = (c % 2 == 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
         if (v) begin gen_next(b); n++; end
         else b = 1'($urandom);
         cyc(0, v, b);
         vectors++;
         if ({locked, err} !== {n >= 21, 1'b0}) begin
            miscompares++;
            $display("FAIL gapped_lock cycle %0d valid %0d: got %b/%b want %b/0", c, n, locked, err, n >= 21);
         end
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL gapped_model cycle %0d: got %h want %h", c, obs(), expv());
         end
      end
   endtask

   task automatic test_single_error();
      bit b;
      lock_up();
      for (int k = 1; k <= 140; k++) begin
         gen_next(b);
         if (k == 40) b = ~b;
         cyc(0, 1, b);
         vectors++;
         if ({locked, err, err_cnt} !== {1'b1, k == 40, (k >= 40) ? 16'd1 : 16'd0}) begin
            miscompares++;
            $display("FAIL single_error bit %0d: got %b/%b/%0d want 1/%b/%0d", k, locked, err, err_cnt, k == 40, k >= 40);
         end
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL single_model bit %0d: got %h want %h", k, obs(), expv());
         end
      end
   endtask

   task automatic test_loss();
      bit b, inj, exp_l;
      int ninj = 0;
      lock_up();
      for (int k = 1; k <= 60; k++) begin
         gen_next(b);
         inj = (k == 5 || k == 8 || k == 11 || k == 14);
         if (inj) begin b = ~b; ninj++; end
         cyc(0, 1, b);
         exp_l = (k < 14) || (k - 14 >= 21);
         vectors++;
         if ({locked, err, err_cnt} !== {exp_l, inj, 16'(ninj)}) begin
            miscompares++;
            $display("FAIL loss bit %0d: got %b/%b/%0d want %b/%b/%0d", k, locked, err, err_cnt, exp_l, inj, ninj);
         end
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL loss_model bit %0d: got %h want %h", k, obs(), expv());
         end
      end
   endtask

   task automatic test_zero();
      cyc(1, 0, 0);
      for (int k = 1; k <= 200; k++) begin
         cyc(0, 1, 0);
         vectors++;
         if ({locked, err, err_cnt} !== 18'd0) begin
            miscompares++;
            $display("FAIL zero_stream bit %0d: got %b/%b/%0d want 0/0/0", k, locked, err, err_cnt);
         end
      end
      vectors++;
      if (obs() !== expv()) begin
         miscompares++;
         $display("FAIL zero_model: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_rst_midlock();
      bit b;
      lock_up();
      for (int k = 1; k <= 15; k++) begin
         gen_next(b);
         if (k == 5 || k == 8 || k == 11) b = ~b;
         cyc(0, 1, b);
      end
      vectors++;
      if ({locked, err_cnt} !== {1'b1, 16'd3}) begin
         miscompares++;
         $display("FAIL pre_rst: got %b/%0d want 1/3", locked, err_cnt);
      end
      gen_next(b);
      cyc(1, 1, b);
      vectors++;
      if (obs() !== 50'd0) begin
         miscompares++;
         $display("FAIL rst_midlock: got %h want 0", obs());
      end
      for (int n = 1; n <= 25; n++) begin
         gen_next(b);
         cyc(0, 1, b);
         vectors++;
         if ({locked, err_cnt} !== {n >= 21, 16'd0}) begin
            miscompares++;
            $display("FAIL relock bit %0d: got %b/%0d want %b/0", n, locked, err_cnt, n >= 21);
         end
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL relock_model bit %0d: got %h want %h", n, obs(), expv());
         end
      end
   endtask

   task automatic test_random();
      bit b, v, r;
      gen_reset();
      cyc(1, 0, 0);
      for (int c = 0; c < 2000; c++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 499) == 0);
         if (v) begin
            gen_next(b);
            if ($urandom_range(0, 29) == 0) b = ~b;
         end else begin
            b = 1'($urandom);
         end
         cyc(r, v, b);
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL random cycle %0d: got %h want %h", c, obs(), expv());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_lock();
      test_gapped();
      test_single_error();
      test_loss();
      test_zero();
      test_rst_midlock();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
